jh_external_reg_fifo: RTL and testbench

- Synchronous, register-based FIFO with valid/ready handshakes on both sides and first-word-fall-through output.
- Used as a small elastic buffer between a producer and a consumer in the same clock domain.
- Provides an occupancy count and a synchronous clear.

---
 rtl/jh_external_reg_fifo.sv | 86 ++++++++
 tb/tb_jh_external_reg_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/jh_external_reg_fifo.sv
// jh_external_reg_fifo: register-based synchronous FIFO with first-word-fall-through output.
// It acts as a small elastic buffer between a producer and a consumer in one clock domain.
//
// Ports:
//   clk       - single clock; all state updates on the rising edge
//   rstn      - asynchronous active-low reset; empties the FIFO and zeroes the storage
//   in_data   - write data
//   in_valid  - write request
//   in_ready  - FIFO can accept a word (not full)
//   out_data  - head-of-FIFO data (stale when out_valid is low)
//   out_valid - FIFO holds at least one word
//   out_ready - consumer accepts the head word
//   clear     - synchronous flush; takes priority over push and pop
//   count     - number of stored words, 0..FIFO_DEPTH
module jh_external_reg_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              clear,
    output logic [$clog2(FIFO_DEPTH):0]       count
);

    localparam int unsigned LB_FIFO_DEPTH = $clog2(FIFO_DEPTH);
    localparam logic [LB_FIFO_DEPTH:0] FULL_COUNT = (LB_FIFO_DEPTH + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [LB_FIFO_DEPTH-1:0] r_wr_ptr;
    logic [LB_FIFO_DEPTH-1:0] r_rd_ptr;
    logic [LB_FIFO_DEPTH:0]   r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != FULL_COUNT);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign out_data  = r_mem[r_rd_ptr];

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Storage: only written on an accepted push that is not overridden by clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LB_FIFO_DEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LB_FIFO_DEPTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (LB_FIFO_DEPTH + 1)'(1);
                2'b01:   r_count <= r_count - (LB_FIFO_DEPTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_jh_external_reg_fifo.sv
module tb_jh_external_reg_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clear;
    logic [2:0]    count;

    jh_external_reg_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .clear     (clear),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          clr;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        int            exp_cnt;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] sb[$];
    int            total;
    int            bad;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic clr, input logic iv,
                                input logic [DW-1:0] d, input logic ordy, input int exp_cnt);
        vec_t v;
        v.name = name; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy; v.exp_cnt = exp_cnt;
        tbl.push_back(v);
    endfunction

    // Drive one cycle starting just after a falling edge; check pre-edge status against the
    // scoreboard, then apply the edge and update the scoreboard.
    task automatic step(input string name, input logic c, input logic iv,
                        input logic [DW-1:0] d, input logic ordy);
        bit m_push;
        bit m_pop;
        clear = c; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        chk({name, ".count"},     int'(count),     sb.size());
        chk({name, ".in_ready"},  int'(in_ready),  int'(sb.size() != DEPTH));
        chk({name, ".out_valid"}, int'(out_valid), int'(sb.size() != 0));
        if (sb.size() != 0) chk({name, ".out_data"}, int'(out_data), int'(sb[0]));
        m_push = iv && (sb.size() != DEPTH);
        m_pop  = ordy && (sb.size() != 0);
        @(posedge clk);
        if (c) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) sb.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] fill [4];
        fill[0] = 8'h3A; fill[1] = 8'h91; fill[2] = 8'h07; fill[3] = 8'hFE;
        total = 0; bad = 0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Fill, overflow, drain, empty pop.
        for (int i = 0; i < 4; i++) add("fill", 1'b0, 1'b1, fill[i], 1'b0, i + 1);
        add("ovf", 1'b0, 1'b1, 8'h55, 1'b0, 4);
        add("ovf", 1'b0, 1'b1, 8'h55, 1'b0, 4);
        for (int i = 0; i < 4; i++) add("drain", 1'b0, 1'b0, 8'h00, 1'b1, 3 - i);
        add("empty_pop", 1'b0, 1'b0, 8'h00, 1'b1, 0);
        // Wrap with simultaneous push/pop holding two words.
        add("pre", 1'b0, 1'b1, 8'hA0, 1'b0, 1);
        add("pre", 1'b0, 1'b1, 8'hA1, 1'b0, 2);
        for (int i = 0; i < 10; i++) add("simul", 1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1, 2);
        add("post", 1'b0, 1'b0, 8'h00, 1'b1, 1);
        add("post", 1'b0, 1'b0, 8'h00, 1'b1, 0);
        // Clear with a concurrent push, then a push from the reset pointers.
        add("c_fill", 1'b0, 1'b1, 8'h11, 1'b0, 1);
        add("c_fill", 1'b0, 1'b1, 8'h22, 1'b0, 2);
        add("c_fill", 1'b0, 1'b1, 8'h33, 1'b0, 3);
        add("clear", 1'b1, 1'b1, 8'h44, 1'b0, 0);
        add("after_clr", 1'b0, 1'b0, 8'h00, 1'b0, 0);
        add("after_clr", 1'b0, 1'b1, 8'h66, 1'b0, 1);
        add("after_clr", 1'b0, 1'b0, 8'h00, 1'b1, 0);

        rstn = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset.in_ready", int'(in_ready), 1);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.count", int'(count), 0);
        chk("reset.out_data", int'(out_data), 0);

        foreach (tbl[i]) begin
            step(tbl[i].name, tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk({tbl[i].name, ".cnt_after"}, int'(count), tbl[i].exp_cnt);
        end

        // Asynchronous reset between edges with data stored.
        step("ar_fill", 1'b0, 1'b1, 8'h77, 1'b0);
        step("ar_fill", 1'b0, 1'b1, 8'h88, 1'b0);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        sb.delete();
        chk("async_rst.count", int'(count), 0);
        chk("async_rst.out_valid", int'(out_valid), 0);
        chk("async_rst.in_ready", int'(in_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        step("ar_after", 1'b0, 1'b1, 8'h99, 1'b0);
        step("ar_after", 1'b0, 1'b0, 8'h00, 1'b1);
        step("ar_end", 1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
